// File: rtl/lib_rr_fifo_arbiter.sv
// Round-robin merge of N show-ahead FIFO heads into one registered output word,
// with optional packet locking so multi-word packets stay contiguous.
module lib_rr_fifo_arbiter #(
    parameter int N        = 4,
    parameter int WIDTH    = 16,
    parameter bit PKT_LOCK = 1'b0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N*WIDTH-1:0]     i_data,
    input  logic [N-1:0]           i_data_val,
    output logic [N-1:0]           o_en,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_data_val,
    output logic [$clog2(N)-1:0]   o_port,
    input  logic                   i_en
);

    localparam int PW = $clog2(N);

    typedef enum logic {
        ST_OPEN   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          state_reg, state_next;
    logic [PW-1:0]   lock_port_reg, lock_port_next;
    logic [PW-1:0]   ptr_reg, ptr_next;

    logic [WIDTH-1:0] o_data_reg;
    logic             o_data_val_reg;
    logic [PW-1:0]    o_port_reg;

    logic             load;
    logic             cand_found;
    logic [PW-1:0]    cand_port;
    logic             grant_valid;
    logic [PW-1:0]    grant_port;
    logic [WIDTH-1:0] grant_word;
    logic             grant_tail;

    logic [WIDTH-1:0] head [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_head
        assign head[gi] = i_data[gi*WIDTH +: WIDTH];
    end

    assign load       = !o_data_val_reg || i_en;
    assign grant_word = head[grant_port];
    assign grant_tail = grant_word[WIDTH-1];

    // Scan from the highest offset down so the last hit is the one nearest ptr.
    always_comb begin
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        cand_found = 1'b0;
        cand_port  = '0;
        sum        = '0;
        idx        = '0;
        for (int i = N - 1; i >= 0; i--) begin
            sum = {1'b0, ptr_reg} + (PW+1)'(i);
            if (sum >= (PW+1)'(N)) begin
                sum = sum - (PW+1)'(N);
            end
            idx = sum[PW-1:0];
            if (i_data_val[idx]) begin
                cand_found = 1'b1;
                cand_port  = idx;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_OPEN;
            lock_port_reg <= '0;
            ptr_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            lock_port_reg <= lock_port_next;
            ptr_reg       <= ptr_next;
        end
    end

    // Next-state logic; ptr only advances on grants that leave the FSM open
    always_comb begin
        state_next     = state_reg;
        lock_port_next = lock_port_reg;
        ptr_next       = ptr_reg;
        if (grant_valid) begin
            if (PKT_LOCK && !grant_tail) begin
                state_next     = ST_LOCKED;
                lock_port_next = grant_port;
            end else begin
                state_next = ST_OPEN;
                ptr_next   = (grant_port == PW'(N - 1)) ? '0 : grant_port + 1'b1;
            end
        end
    end

    // Output logic: grant selection never looks at i_data
    always_comb begin
        grant_port  = cand_port;
        grant_valid = cand_found;
        if (state_reg == ST_LOCKED) begin
            grant_port  = lock_port_reg;
            grant_valid = i_data_val[lock_port_reg];
        end
        if (reset || !load) begin
            grant_valid = 1'b0;
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_en
        assign o_en[gi] = grant_valid && (grant_port == PW'(gi));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            o_data_reg     <= '0;
            o_data_val_reg <= 1'b0;
            o_port_reg     <= '0;
        end else if (grant_valid) begin
            o_data_reg     <= grant_word;
            o_data_val_reg <= 1'b1;
            o_port_reg     <= grant_port;
        end else if (load) begin
            o_data_val_reg <= 1'b0;
        end
    end

    assign o_data     = o_data_reg;
    assign o_data_val = o_data_val_reg;
    assign o_port     = o_port_reg;

endmodule

// File: tb/tb_lib_rr_fifo_arbiter.sv
// Bench for lib_rr_fifo_arbiter: a plain round-robin instance and a packet-lock
// instance share directed stimulus; a reference model checks both every cycle.
module tb_lib_rr_fifo_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] i_data;
    logic [3:0]  i_data_val;
    logic        i_en;

    logic [3:0]  en_w   [2];
    logic [7:0]  data_w [2];
    logic        val_w  [2];
    logic [1:0]  port_w [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lib_rr_fifo_arbiter #(.N(4), .WIDTH(8), .PKT_LOCK(1'b0)) u_rr (
        .clk(clk), .reset(reset), .i_data(i_data), .i_data_val(i_data_val),
        .o_en(en_w[0]), .o_data(data_w[0]), .o_data_val(val_w[0]),
        .o_port(port_w[0]), .i_en(i_en)
    );

    lib_rr_fifo_arbiter #(.N(4), .WIDTH(8), .PKT_LOCK(1'b1)) u_pk (
        .clk(clk), .reset(reset), .i_data(i_data), .i_data_val(i_data_val),
        .o_en(en_w[1]), .o_data(data_w[1]), .o_data_val(val_w[1]),
        .o_port(port_w[1]), .i_en(i_en)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_head(input int k, input logic [7:0] v);
        i_data[k*8 +: 8] = v;
    endtask

    // Reference model: instance 0 plain round robin, instance 1 packet lock (bit 7 = tail)
    int         m_ptr   [2];
    bit         m_lock  [2];
    int         m_lport [2];
    logic [7:0] m_data  [2];
    bit         m_val   [2];
    int         m_port  [2];
    bit         m_init = 1'b0;

    always @(negedge clk) begin
        int         g;
        bit         gv;
        logic [3:0] exp_en;
        string      pfx;
        for (int p = 0; p < 2; p++) begin
            pfx = (p == 0) ? "rr" : "pk";
            gv  = 1'b0;
            g   = 0;
            if (m_init && !reset && (!m_val[p] || i_en)) begin
                if (m_lock[p]) begin
                    if (i_data_val[m_lport[p]]) begin
                        gv = 1'b1;
                        g  = m_lport[p];
                    end
                end else begin
                    for (int k = 3; k >= 0; k--) begin
                        if (i_data_val[(m_ptr[p] + k) % 4]) begin
                            gv = 1'b1;
                            g  = (m_ptr[p] + k) % 4;
                        end
                    end
                end
            end
            exp_en = gv ? 4'(1 << g) : 4'b0000;
            if (m_init) begin
                chk({pfx, "_o_en"}, 32'(en_w[p]), 32'(exp_en));
                chk({pfx, "_o_data_val"}, 32'(val_w[p]), 32'(m_val[p]));
                chk({pfx, "_o_data"}, 32'(data_w[p]), 32'(m_data[p]));
                chk({pfx, "_o_port"}, 32'(port_w[p]), 32'(m_port[p]));
                $display("cyc %0t %s en=%b val=%0d data=%h port=%0d", $time, pfx,
                         en_w[p], val_w[p], data_w[p], port_w[p]);
            end
            if (reset) begin
                m_ptr[p] = 0; m_lock[p] = 1'b0; m_lport[p] = 0;
                m_data[p] = 8'h00; m_val[p] = 1'b0; m_port[p] = 0;
            end else if (gv) begin
                m_data[p] = i_data[g*8 +: 8];
                m_val[p]  = 1'b1;
                m_port[p] = g;
                if (p == 1 && !i_data[g*8 + 7]) begin
                    m_lock[p]  = 1'b1;
                    m_lport[p] = g;
                end else begin
                    m_lock[p] = 1'b0;
                    m_ptr[p]  = (g + 1) % 4;
                end
            end else if (m_init && (!m_val[p] || i_en)) begin
                m_val[p] = 1'b0;
            end
        end
        if (reset) m_init = 1'b1;
    end

    initial begin
        // Reset with every head valid
        reset = 1'b1; i_en = 1'b1; i_data_val = 4'hF; i_data = 32'h43322110;
        for (int r = 0; r < 2; r++) begin
            tick();
            chk("rst_o_en", 32'(en_w[0]), 32'h0);
            chk("rst_pk_o_en", 32'(en_w[1]), 32'h0);
            chk("rst_o_data_val", 32'(val_w[0]), 32'h0);
            chk("rst_o_data", 32'(data_w[0]), 32'h0);
            chk("rst_o_port", 32'(port_w[0]), 32'h0);
        end
        reset = 1'b0;
        #1 chk("first_grant", 32'(en_w[0]), 32'h1);

        // Fairness: ports in order 0,1,2,3,0 back to back
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("fair_port", 32'(port_w[0]), 32'(k % 4));
            chk("fair_data", 32'(data_w[0]), 32'(8'h10 + 8'h11 * (k % 4)));
            chk("fair_val", 32'(val_w[0]), 32'h1);
            chk("fair_onehot", 32'($countones(en_w[0])), 32'h1);
        end

        // Back-pressure on port 2
        reset = 1'b1; tick(); reset = 1'b0;
        i_data_val = 4'b0100; set_head(2, 8'hA5); i_en = 1'b0;
        #1 chk("bp_first_en", 32'(en_w[0]), 32'h4);
        tick();
        chk("bp_load_data", 32'(data_w[0]), 32'hA5);
        for (int k = 0; k < 3; k++) begin
            chk("bp_stall_en", 32'(en_w[0]), 32'h0);
            tick();
            chk("bp_hold_data", 32'(data_w[0]), 32'hA5);
            chk("bp_hold_val", 32'(val_w[0]), 32'h1);
        end
        i_en = 1'b1; set_head(2, 8'h5A);
        #1 chk("bp_release_en", 32'(en_w[0]), 32'h4);
        tick();
        chk("bp_next_data", 32'(data_w[0]), 32'h5A);

        // Sparse requests with ptr at 3, then wrap to port 0
        i_data_val = 4'b0010; set_head(1, 8'h11);
        #1 chk("sparse_en1", 32'(en_w[0]), 32'h2);
        tick();
        chk("sparse_port1", 32'(port_w[0]), 32'h1);
        i_data_val = 4'b0001; set_head(0, 8'h22);
        #1 chk("wrap_en0", 32'(en_w[0]), 32'h1);
        tick();
        chk("wrap_port0", 32'(port_w[0]), 32'h0);

        // Empty inputs: valid drops, data holds
        i_data_val = 4'b0000;
        #1 chk("empty_en", 32'(en_w[0]), 32'h0);
        tick();
        chk("empty_val", 32'(val_w[0]), 32'h0);
        chk("empty_data_hold", 32'(data_w[0]), 32'h22);
        tick();
        chk("empty_val2", 32'(val_w[0]), 32'h0);

        // Packet lock: single tail word on port 0 moves ptr to 1
        reset = 1'b1; tick(); reset = 1'b0;
        i_data_val = 4'b0001; set_head(0, 8'h80);
        #1 chk("pk_single_en", 32'(en_w[1]), 32'h1);
        tick();
        chk("pk_single_data", 32'(data_w[1]), 32'h80);
        i_data_val = 4'b1011; set_head(0, 8'h44); set_head(1, 8'h01); set_head(3, 8'hB3);
        #1 chk("pk_w0_en", 32'(en_w[1]), 32'h2);
        tick();
        chk("pk_w0_port", 32'(port_w[1]), 32'h1);
        chk("pk_w0_data", 32'(data_w[1]), 32'h01);
        set_head(1, 8'h02);
        #1 chk("pk_w1_en", 32'(en_w[1]), 32'h2);
        tick();
        chk("pk_w1_port", 32'(port_w[1]), 32'h1);
        chk("pk_w1_data", 32'(data_w[1]), 32'h02);
        i_data_val = 4'b1001;
        #1 chk("pk_bubble_en", 32'(en_w[1]), 32'h0);
        tick();
        chk("pk_bubble_val", 32'(val_w[1]), 32'h0);
        i_data_val = 4'b1011; set_head(1, 8'h83);
        #1 chk("pk_tail_en", 32'(en_w[1]), 32'h2);
        tick();
        chk("pk_tail_port", 32'(port_w[1]), 32'h1);
        chk("pk_tail_data", 32'(data_w[1]), 32'h83);
        #1 chk("pk_after_en", 32'(en_w[1]), 32'h8);
        tick();
        chk("pk_after_port", 32'(port_w[1]), 32'h3);
        chk("pk_after_data", 32'(data_w[1]), 32'hB3);

        // Reset in the middle of a locked packet
        i_data_val = 4'b0010; set_head(1, 8'h05);
        tick();
        chk("pk_mid_port", 32'(port_w[1]), 32'h1);
        reset = 1'b1; i_data_val = 4'hF;
        #1 chk("pk_rst_en", 32'(en_w[1]), 32'h0);
        tick();
        chk("pk_rst_val", 32'(val_w[1]), 32'h0);
        reset = 1'b0; i_data_val = 4'b1001;
        #1 chk("pk_rst_open_en", 32'(en_w[1]), 32'h1);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
